// File: rtl/cond_code_unit.sv
// Condition-code register, cmovXX/jXX condition evaluator and run/halt FSM.
// Optional saturating CC update counter enabled by defining CC_COUNT_EN.
module cond_code_unit #(
    parameter int CNT_W = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [0:2]       ConditionCodes_New,
    input  logic             Stall,
    input  logic             Exc_In,
    input  logic             Halt_In,
    output logic [0:2]       ConditionCodes_Out,
    output logic             Condition,
`ifdef CC_COUNT_EN
    output logic [CNT_W-1:0] UpdateCount,
`endif
    output logic             Halted
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    localparam logic [3:0] OPQ   = 4'h6;
    localparam logic [3:0] CMOV  = 4'h2;
    localparam logic [3:0] JXX   = 4'h7;

    state_t state;
    logic   set_cc;
    logic   zf;
    logic   sf;
    logic   of;
    logic   lt;
    logic   cond_sel;

    assign set_cc = (state == RUN) && (icode == OPQ) && !Stall && !Exc_In;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state              <= RUN;
            Halted             <= 1'b0;
            ConditionCodes_Out <= 3'b100;
        end else begin
            if (set_cc)
                ConditionCodes_Out <= ConditionCodes_New;
            case (state)
                RUN: begin
                    if (Halt_In || Exc_In) begin
                        state  <= HALTED;
                        Halted <= 1'b1;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    Halted <= 1'b1;
                end
                default: begin
                    state  <= RUN;
                    Halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef CC_COUNT_EN
    always_ff @(posedge Clk) begin
        if (!Rst_n)
            UpdateCount <= '0;
        else if (set_cc && !(&UpdateCount))
            UpdateCount <= UpdateCount + 1'b1;
    end
`endif

    // Evaluated from the registered flags only, so an instruction never sees its own OPq result.
    assign zf = ConditionCodes_Out[0];
    assign sf = ConditionCodes_Out[1];
    assign of = ConditionCodes_Out[2];
    assign lt = sf ^ of;

    always_comb begin
        cond_sel = 1'b0;
        case (ifun)
            4'h0:    cond_sel = 1'b1;
            4'h1:    cond_sel = zf | lt;
            4'h2:    cond_sel = lt;
            4'h3:    cond_sel = zf;
            4'h4:    cond_sel = ~zf;
            4'h5:    cond_sel = ~lt;
            4'h6:    cond_sel = ~zf & ~lt;
            default: cond_sel = 1'b0;
        endcase
    end

    assign Condition = (icode == CMOV || icode == JXX) ? cond_sel : 1'b1;

endmodule

// File: doc/cond_code_unit.md
Name: cond_code_unit

Overview:
- Condition-code register and condition evaluator that sits opposite the Execute stage.
- Latches the Zero/Sign/Overflow flags that Execute produces for OPq and feeds them back to Execute as ConditionCodes_In.
- Resolves the cmovXX / jXX Condition signal from the stored flags.
- Holds a small run/halt state machine so that flags freeze once the processor halts or takes an exception.

Parameters:
- CNT_W, 32, width of the optional CC update counter (only used when CC_COUNT_EN is defined).

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  synchronous active-low reset
- icode  input  4  instruction code currently in Execute
- ifun  input  4  function code currently in Execute
- ConditionCodes_New  input  [0:2]  flags computed by Execute this cycle: [0]=ZF, [1]=SF, [2]=OF
- Stall  input  1  1 = instruction in Execute does not commit this cycle
- Exc_In  input  1  1 = exception/halt status from a later stage (non-AOK); suppresses CC write
- Halt_In  input  1  1 = halt committed this cycle (icode 0 retired)
- ConditionCodes_Out  output  [0:2]  registered flags, to Execute ConditionCodes_In
- Condition  output  1  resolved condition for cmovXX / jXX
- Halted  output  1  1 when the state machine is in HALTED
- UpdateCount  output  CNT_W  committed CC writes (present only with CC_COUNT_EN)

Behaviour:
- Reset, synchronous on rising Clk with Rst_n=0:
  - ConditionCodes_Out = 3'b100 (ZF=1, SF=0, OF=0)
  - state = RUN, Halted = 0, UpdateCount = 0
  - Reset takes priority over every other input.
  - A reset asserted while HALTED returns the block to RUN in the next cycle.
- State machine, 2 states:
  - RUN: when Halt_In=1 or Exc_In=1, go to HALTED at the next edge; otherwise stay in RUN.
  - HALTED: the only exit is reset. Halted = (state==HALTED), registered.
- CC write enable: Set_CC = (state==RUN) && (icode==4'h6) && !Stall && !Exc_In.
  - When Set_CC=1, ConditionCodes_Out <= ConditionCodes_New at the next rising edge. Latency is 1 cycle.
  - When Set_CC=0, ConditionCodes_Out holds its value.
  - When Halt_In and Set_CC are both 1 in the same cycle, the CC write commits and the state moves to HALTED in that same edge.
- Condition is combinational and is always computed from the registered ConditionCodes_Out, never from ConditionCodes_New. An instruction therefore sees the flags written by earlier instructions only.
  - Applies when icode is 4'h2 or 4'h7. With Z=ZF, S=SF, O=OF:
    - ifun 0: 1
    - ifun 1 (le): Z | (S^O)
    - ifun 2 (l): S^O
    - ifun 3 (e): Z
    - ifun 4 (ne): ~Z
    - ifun 5 (ge): ~(S^O)
    - ifun 6 (g): ~Z & ~(S^O)
    - ifun 7–F: 0
  - Any other icode gives Condition = 1.
  - In HALTED, Condition is still evaluated from the frozen flags.
- ConditionCodes_New is ignored whenever icode != 4'h6. Execute leaves it undriven or stale on those cycles.

Optional Feature:
- Macro CC_COUNT_EN.
- Defined:
  - UpdateCount port exists and increments by 1 on every edge where Set_CC=1.
  - It saturates at all-ones and does not wrap.
  - It resets to 0.
- Undefined: the UpdateCount port and the counter logic are absent, and all other behaviour is identical.

Test Plan:
- Reset then idle: Rst_n=0 for one edge, then icode=4'h1 -> ConditionCodes_Out=100, Condition=1, Halted=0.
- OPq write then branch:
  - Cycle A: icode=6, ConditionCodes_New=010, Stall=0.
  - Next cycle: icode=7, ifun=2 -> ConditionCodes_Out=010 and Condition=1.
  - Same flags with ifun=3 -> Condition=0.
- Suppression:
  - icode=6, New=001, Stall=1 -> flags stay 100.
  - Repeat with Exc_In=1 -> flags stay 100 and Halted=1 next cycle.
  - A following icode=6, New=010 -> flags still 100.
- Full cmov table: preload flags 011 (SF=1, OF=1) -> ifun 0..6 give Condition 1,0,0,0,1,1,1; ifun=7 gives 0.
- Simultaneous events: icode=6, New=110, Halt_In=1 -> next cycle flags=110 and Halted=1. Then Rst_n=0 -> flags=100, Halted=0.
- CC_COUNT_EN with CNT_W=2: five committed OPq writes -> UpdateCount reads 1, 2, 3, 3, 3. A stalled OPq does not increment it.
